// File: rtl/dvp_pattern_source.sv
// rtl/dvp_pattern_source.sv - DVP camera emulator with frame timing and RGB565 test patterns
module dvp_pattern_source #(
  parameter int DATA_WIDTH  = 8,
  parameter int MAX_WIDTH   = 640,
  parameter int MAX_HEIGHT  = 480,
  parameter int HTS         = 1896,
  parameter int HFP         = 20,
  parameter int VSYNC_LINES = 3,
  parameter int VBP_LINES   = 10,
  parameter int VFP_LINES   = 10,
  parameter int CLK_DIV     = 1
) (
  input  logic                  clk_i,
  input  logic                  resetn_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic [1:0]            mode_i,
  input  logic [15:0]           frames_i,
  input  logic [15:0]           resolution_width_i,
  input  logic [15:0]           resolution_depth_i,
  output logic                  cam_vsync,
  output logic                  cam_href,
  output logic [DATA_WIDTH-1:0] cam_half_pixel_o,
  output logic                  busy_o,
  output logic                  frame_done_o,
  output logic [15:0]           frame_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_VSYNC, S_VBP, S_HFP, S_ACTIVE, S_HBLANK, S_VFP
  } state_t;

  state_t        state;
  logic [4:0]    div_cnt;
  logic          tick;
  logic [31:0]   cnt;
  logic [31:0]   dur;
  logic          last;
  logic [15:0]   y_cnt;
  logic [15:0]   pix_idx;
  logic [15:0]   bar_pos;
  logic [2:0]    bar_idx;
  logic [15:0]   bar_w;
  logic [15:0]   w_lat;
  logic [15:0]   h_lat;
  logic [1:0]    mode_lat;
  logic [15:0]   frames_lat;
  logic          start_pend;
  logic          stop_pend;
  logic [15:0]   w_clamp;
  logic [15:0]   h_clamp;
  logic signed [31:0] hb_raw;
  logic [15:0]   x_pix;
  logic [15:0]   pixel;
  logic [7:0]    cur_byte;
  logic [15:0]   frame_cnt_nxt;

  assign tick          = (div_cnt == 5'd0);
  assign w_clamp       = (resolution_width_i == 16'd0 || resolution_width_i > 16'(MAX_WIDTH))
                         ? 16'(MAX_WIDTH) : resolution_width_i;
  assign h_clamp       = (resolution_depth_i == 16'd0 || resolution_depth_i > 16'(MAX_HEIGHT))
                         ? 16'(MAX_HEIGHT) : resolution_depth_i;
  assign hb_raw        = HTS - HFP - $signed({15'd0, w_lat, 1'b0});
  assign bar_w         = w_lat >> 3;
  assign x_pix         = cnt[16:1];
  assign last          = (cnt == dur - 32'd1);
  assign frame_cnt_nxt = frame_cnt_o + 16'd1;

  // Clock divider: one tick every CLK_DIV cycles, first tick right after reset
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      div_cnt <= 5'd0;
    end else if (div_cnt == 5'(CLK_DIV - 1)) begin
      div_cnt <= 5'd0;
    end else begin
      div_cnt <= div_cnt + 5'd1;
    end
  end

  // Length in ticks of the current state; HBLANK never shrinks below one tick
  always_comb begin
    dur = 32'd1;
    case (state)
      S_VSYNC:  dur = 32'(VSYNC_LINES * HTS);
      S_VBP:    dur = 32'(VBP_LINES * HTS);
      S_HFP:    dur = 32'(HFP);
      S_ACTIVE: dur = {15'd0, w_lat, 1'b0};
      S_HBLANK: dur = (hb_raw < 32'sd1) ? 32'd1 : unsigned'(hb_raw);
      S_VFP:    dur = 32'(VFP_LINES * HTS);
      default:  dur = 32'd1;
    endcase
  end

  // Pattern generator for the pixel addressed by the current ACTIVE byte
  always_comb begin
    pixel = 16'h0000;
    case (mode_lat)
      2'd0: begin
        case (bar_idx)
          3'd0:    pixel = 16'hFFFF;
          3'd1:    pixel = 16'hFFE0;
          3'd2:    pixel = 16'h07FF;
          3'd3:    pixel = 16'h07E0;
          3'd4:    pixel = 16'hF81F;
          3'd5:    pixel = 16'hF800;
          3'd6:    pixel = 16'h001F;
          default: pixel = 16'h0000;
        endcase
      end
      2'd1:    pixel = {x_pix[7:3], x_pix[7:2], x_pix[7:3]};
      2'd2:    pixel = (x_pix[3] ^ y_cnt[3]) ? 16'hFFFF : 16'h0000;
      default: pixel = pix_idx;
    endcase
    cur_byte = cnt[0] ? pixel[7:0] : pixel[15:8];
  end

  // Frame sequencer; outputs show the state that was current at each tick
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state            <= S_IDLE;
      cnt              <= 32'd0;
      y_cnt            <= 16'd0;
      pix_idx          <= 16'd0;
      bar_pos          <= 16'd0;
      bar_idx          <= 3'd0;
      w_lat            <= 16'd0;
      h_lat            <= 16'd0;
      mode_lat         <= 2'd0;
      frames_lat       <= 16'd0;
      start_pend       <= 1'b0;
      stop_pend        <= 1'b0;
      cam_vsync        <= 1'b1;
      cam_href         <= 1'b0;
      cam_half_pixel_o <= '0;
      busy_o           <= 1'b0;
      frame_done_o     <= 1'b0;
      frame_cnt_o      <= 16'd0;
    end else begin
      frame_done_o <= 1'b0;
      if (state == S_IDLE && start_i) start_pend <= 1'b1;
      if (stop_i && (state != S_IDLE || start_i || start_pend)) stop_pend <= 1'b1;
      if (tick) begin
        cam_vsync        <= (state == S_IDLE) || (state == S_VSYNC) || (state == S_VFP);
        cam_href         <= (state == S_ACTIVE);
        cam_half_pixel_o <= (state == S_ACTIVE) ? cur_byte : '0;
        cnt              <= last ? 32'd0 : cnt + 32'd1;
        case (state)
          S_IDLE: begin
            if (start_i || start_pend) begin
              state       <= S_VSYNC;
              start_pend  <= 1'b0;
              busy_o      <= 1'b1;
              frames_lat  <= frames_i;
              frame_cnt_o <= 16'd0;
              w_lat       <= w_clamp;
              h_lat       <= h_clamp;
              mode_lat    <= mode_i;
              pix_idx     <= 16'd0;
            end
          end
          S_VSYNC: if (last) state <= S_VBP;
          S_VBP: begin
            if (last) begin
              state <= S_HFP;
              y_cnt <= 16'd0;
            end
          end
          S_HFP: begin
            bar_pos <= 16'd0;
            bar_idx <= (bar_w == 16'd0) ? 3'd7 : 3'd0;
            if (last) state <= S_ACTIVE;
          end
          S_ACTIVE: begin
            if (cnt[0]) begin
              pix_idx <= pix_idx + 16'd1;
              if (bar_pos + 16'd1 == bar_w) begin
                bar_pos <= 16'd0;
                if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
              end else begin
                bar_pos <= bar_pos + 16'd1;
              end
            end
            if (last) state <= S_HBLANK;
          end
          S_HBLANK: begin
            if (last) begin
              if (y_cnt == h_lat - 16'd1) begin
                state <= S_VFP;
              end else begin
                state <= S_HFP;
                y_cnt <= y_cnt + 16'd1;
              end
            end
          end
          S_VFP: begin
            if (last) begin
              frame_done_o <= 1'b1;
              frame_cnt_o  <= frame_cnt_nxt;
              if (stop_pend || (frames_lat != 16'd0 && frame_cnt_nxt == frames_lat)) begin
                state     <= S_IDLE;
                busy_o    <= 1'b0;
                stop_pend <= 1'b0;
              end else begin
                state    <= S_VSYNC;
                w_lat    <= w_clamp;
                h_lat    <= h_clamp;
                mode_lat <= mode_i;
                pix_idx  <= 16'd0;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dvp_pattern_source.sv
// tb/tb_dvp_pattern_source.sv - scoreboard bench for dvp_pattern_source
module tb_dvp_pattern_source;

  logic        tb_vgaClock = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_start = 1'b0;
  logic        b_start = 1'b0;
  logic        stop = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] frames = 16'd0;
  logic [15:0] width = 16'd16;
  logic [15:0] depth = 16'd4;

  logic        a_vsync, a_href, a_busy, a_fd;
  logic [7:0]  a_data;
  logic [15:0] a_fcnt;
  logic        b_vsync, b_href, b_busy, b_fd;
  logic [7:0]  b_data;
  logic [15:0] b_fcnt;

  int checks = 0;
  int failures = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];

  logic [7:0] bars_line [32] = '{
    8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'hFF, 8'hE0,
    8'h07, 8'hFF, 8'h07, 8'hFF, 8'h07, 8'hE0, 8'h07, 8'hE0,
    8'hF8, 8'h1F, 8'hF8, 8'h1F, 8'hF8, 8'h00, 8'hF8, 8'h00,
    8'h00, 8'h1F, 8'h00, 8'h1F, 8'h00, 8'h00, 8'h00, 8'h00};

  dvp_pattern_source #(
    .DATA_WIDTH(8), .MAX_WIDTH(16), .MAX_HEIGHT(4), .HTS(64), .HFP(4),
    .VSYNC_LINES(1), .VBP_LINES(2), .VFP_LINES(2), .CLK_DIV(1)
  ) dut_a (
    .clk_i(tb_vgaClock), .resetn_i(rst_n), .start_i(a_start), .stop_i(stop),
    .mode_i(mode), .frames_i(frames), .resolution_width_i(width),
    .resolution_depth_i(depth), .cam_vsync(a_vsync), .cam_href(a_href),
    .cam_half_pixel_o(a_data), .busy_o(a_busy), .frame_done_o(a_fd),
    .frame_cnt_o(a_fcnt)
  );

  dvp_pattern_source #(
    .DATA_WIDTH(8), .MAX_WIDTH(16), .MAX_HEIGHT(4), .HTS(32), .HFP(4),
    .VSYNC_LINES(1), .VBP_LINES(2), .VFP_LINES(2), .CLK_DIV(3)
  ) dut_b (
    .clk_i(tb_vgaClock), .resetn_i(rst_n), .start_i(b_start), .stop_i(stop),
    .mode_i(mode), .frames_i(frames), .resolution_width_i(width),
    .resolution_depth_i(depth), .cam_vsync(b_vsync), .cam_href(b_href),
    .cam_half_pixel_o(b_data), .busy_o(b_busy), .frame_done_o(b_fd),
    .frame_cnt_o(b_fcnt)
  );

  always #5 tb_vgaClock = ~tb_vgaClock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Instance B ticks on every third edge after reset release
  int   ecnt;
  logic b_fresh;
  always @(posedge tb_vgaClock or negedge rst_n) begin
    if (!rst_n) begin
      ecnt    <= 0;
      b_fresh <= 1'b0;
    end else begin
      b_fresh <= (ecnt == 0);
      ecnt    <= (ecnt == 2) ? 0 : ecnt + 1;
    end
  end

  // Monitor A: every HREF byte is popped from the scoreboard
  always @(negedge tb_vgaClock) begin
    if (rst_n && a_href) begin
      if (qa.size() == 0) chk("a_extra_byte", int'(a_data), -1);
      else chk("a_byte", int'(a_data), int'(qa.pop_front()));
    end
  end

  // Monitor B: one pop per tick, outputs must hold between ticks
  logic [9:0] b_last;
  logic       b_have;
  always @(negedge tb_vgaClock) begin
    if (!rst_n) begin
      b_have = 1'b0;
    end else if (b_fresh) begin
      if (b_href) begin
        if (qb.size() == 0) chk("b_extra_byte", int'(b_data), -1);
        else chk("b_byte", int'(b_data), int'(qb.pop_front()));
      end
      b_last = {b_vsync, b_href, b_data};
      b_have = 1'b1;
    end else if (b_have && b_busy) begin
      chk("b_hold", int'({b_vsync, b_href, b_data}), int'(b_last));
    end
  end

  function automatic logic [15:0] model_pixel(input int m, input int x, input int y, input int w);
    logic [15:0] xv;
    logic [15:0] yv;
    logic [15:0] colours [8];
    int bw;
    int bar;
    colours = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    xv = 16'(x);
    yv = 16'(y);
    case (m)
      0: begin
        bw  = w / 8;
        bar = (bw == 0) ? 7 : x / bw;
        if (bar > 7) bar = 7;
        return colours[bar];
      end
      1: return {xv[7:3], xv[7:2], xv[7:3]};
      2: return (xv[3] ^ yv[3]) ? 16'hFFFF : 16'h0000;
      default: return 16'((y * w + x) % 65536);
    endcase
  endfunction

  task automatic push_byte(input bit use_b, input logic [7:0] v);
    if (use_b) qb.push_back(v);
    else qa.push_back(v);
  endtask

  task automatic push_frame(input bit use_b, input int m, input int w, input int h, input bit use_table);
    logic [15:0] p;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        if (use_table) begin
          push_byte(use_b, bars_line[2*x]);
          push_byte(use_b, bars_line[2*x+1]);
        end else begin
          p = model_pixel(m, x, y, w);
          push_byte(use_b, p[15:8]);
          push_byte(use_b, p[7:0]);
        end
      end
    end
  endtask

  bit sel_b;
  int st_busy, st_fd, st_vslow, st_first_hi, st_last_low, st_fd_idx, st_bursts, st_bad, st_timeout;

  // Walks one sequence cycle by cycle, measuring VSYNC/HREF timing
  task automatic capture(input bit use_b, input int burst_len, input int gap_len,
                         input int stop_at, input int bound);
    int idx = 0;
    int run = 0;
    int gap = 0;
    int w = 0;
    bit prev = 1'b0;
    bit seen_low = 1'b0;
    logic s_busy, s_fd, s_vsync, s_href;
    sel_b = use_b;
    st_busy = 0; st_fd = 0; st_vslow = 0; st_first_hi = 0; st_last_low = -1;
    st_fd_idx = -1; st_bursts = 0; st_bad = 0; st_timeout = 0;
    while (!(use_b ? b_busy : a_busy) && w < 10) begin
      w++;
      @(negedge tb_vgaClock);
    end
    forever begin
      stop    = (idx == stop_at);
      s_busy  = use_b ? b_busy : a_busy;
      s_fd    = use_b ? b_fd : a_fd;
      s_vsync = use_b ? b_vsync : a_vsync;
      s_href  = use_b ? b_href : a_href;
      if (s_busy) st_busy++;
      if (s_fd) begin
        st_fd++;
        st_fd_idx = idx;
      end
      if (!s_vsync) begin
        st_vslow++;
        st_last_low = idx;
        seen_low = 1'b1;
      end else if (!seen_low) begin
        st_first_hi++;
      end
      if (s_href) begin
        if (!prev && st_bursts > 0 && gap_len > 0 && gap != gap_len) st_bad++;
        run++;
        gap = 0;
      end else begin
        if (prev) begin
          st_bursts++;
          if (run != burst_len) st_bad++;
          run = 0;
        end
        gap++;
      end
      prev = s_href;
      if (!s_busy) break;
      if (idx >= bound) begin
        st_timeout = 1;
        break;
      end
      idx++;
      @(negedge tb_vgaClock);
    end
    stop = 1'b0;
  endtask

  task automatic run_a(input int m, input int win, input int hin, input int heff, input bit use_table);
    mode   = 2'(m);
    width  = 16'(win);
    depth  = 16'(hin);
    frames = 16'd1;
    push_frame(1'b0, m, 16, heff, use_table);
    @(negedge tb_vgaClock) a_start = 1'b1;
    @(negedge tb_vgaClock) a_start = 1'b0;
    capture(1'b0, 32, 32, -1, 3000);
    chk("a_timeout", st_timeout, 0);
    chk("a_busy_cycles", st_busy, 64 + 128 + 64 * heff + 128);
    chk("a_frame_done_count", st_fd, 1);
    chk("a_bursts", st_bursts, heff);
    chk("a_bad_runs", st_bad, 0);
    chk("a_frame_cnt", int'(a_fcnt), 1);
    chk("a_queue_left", qa.size(), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    bit fd_seen;
    int w;
    repeat (3) @(negedge tb_vgaClock);
    chk("rst_vsync", int'(a_vsync), 1);
    chk("rst_href", int'(a_href), 0);
    chk("rst_data", int'(a_data), 0);
    chk("rst_busy", int'(a_busy), 0);
    chk("rst_frame_done", int'(a_fd), 0);
    chk("rst_frame_cnt", int'(a_fcnt), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge tb_vgaClock);
    chk("idle_vsync", int'(a_vsync), 1);
    chk("idle_busy", int'(b_busy), 0);

    // mode3 full frame with timing
    run_a(3, 16, 4, 4, 1'b0);
    chk("a_vsync_low", st_vslow, 384);
    chk("a_vfp_len", st_fd_idx - st_last_low, 128);
    chk("a_vsync_first_high", int'(st_first_hi >= 64 && st_first_hi <= 65), 1);
    chk("a_busy_after", int'(a_busy), 0);

    // colour bars, grey ramp, checker
    run_a(0, 16, 1, 1, 1'b1);
    run_a(1, 16, 2, 2, 1'b0);
    run_a(2, 16, 4, 4, 1'b0);

    // clamping of width and depth
    run_a(3, 0, 2, 2, 1'b0);
    run_a(3, 100, 0, 4, 1'b0);

    // continuous run stopped mid second frame
    mode = 2'd3; width = 16'd16; depth = 16'd4; frames = 16'd0;
    push_frame(1'b0, 3, 16, 4, 1'b0);
    push_frame(1'b0, 3, 16, 4, 1'b0);
    @(negedge tb_vgaClock) a_start = 1'b1;
    @(negedge tb_vgaClock) a_start = 1'b0;
    capture(1'b0, 32, 0, 864, 4000);
    chk("stop_timeout", st_timeout, 0);
    chk("stop_busy_cycles", st_busy, 1152);
    chk("stop_frame_done_count", st_fd, 2);
    chk("stop_frame_cnt", int'(a_fcnt), 2);
    chk("stop_queue_left", qa.size(), 0);
    repeat (200) @(negedge tb_vgaClock);
    chk("stop_stays_idle", int'(a_busy), 0);

    // reset in the middle of an active line
    frames = 16'd1;
    push_frame(1'b0, 3, 16, 4, 1'b0);
    @(negedge tb_vgaClock) a_start = 1'b1;
    @(negedge tb_vgaClock) a_start = 1'b0;
    w = 0;
    while (!a_href && w < 1000) begin
      w++;
      @(negedge tb_vgaClock);
    end
    chk("rst_mid_reached_active", int'(a_href), 1);
    repeat (3) @(negedge tb_vgaClock);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_vsync", int'(a_vsync), 1);
    chk("rst_mid_href", int'(a_href), 0);
    chk("rst_mid_data", int'(a_data), 0);
    chk("rst_mid_busy", int'(a_busy), 0);
    fd_seen = 1'b0;
    repeat (5) begin
      @(negedge tb_vgaClock);
      if (a_fd) fd_seen = 1'b1;
    end
    qa.delete();
    rst_n = 1'b1;
    repeat (20) @(negedge tb_vgaClock);
    if (a_fd) fd_seen = 1'b1;
    chk("rst_mid_no_frame_done", int'(fd_seen), 0);
    chk("rst_mid_frame_cnt", int'(a_fcnt), 0);

    // divided clock with minimal horizontal blanking
    mode = 2'd3; width = 16'd16; depth = 16'd4; frames = 16'd1;
    push_frame(1'b1, 3, 16, 4, 1'b0);
    @(negedge tb_vgaClock) b_start = 1'b1;
    @(negedge tb_vgaClock) b_start = 1'b0;
    capture(1'b1, 96, 15, -1, 4000);
    chk("b_timeout", st_timeout, 0);
    chk("b_busy_cycles", st_busy, 924);
    chk("b_frame_done_count", st_fd, 1);
    chk("b_bursts", st_bursts, 4);
    chk("b_bad_runs", st_bad, 0);
    chk("b_frame_cnt", int'(b_fcnt), 1);
    chk("b_queue_left", qb.size(), 0);

    repeat (10) @(negedge tb_vgaClock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
